// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state encoding for the program loader
package prog_loader_pkg;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 12;
    localparam int MEM_DEPTH = 2048;
    localparam int CNT_W     = 12;

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CSUM    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERROR   = 4'd8
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that writes a checksummed 12-bit program image into memory
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t            state;
    state_t            state_next;
    logic [7:0]        sum;
    logic [7:0]        sum_next;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  len_rx;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        hi_nib;
    logic [DATA_W-1:0] wdata;
    logic              accept;
    logic              len_legal;
    logic              session_start;

    assign accept        = rx_valid && rx_ready;
    assign sum_next      = sum + rx_data;
    assign len_rx        = {len[CNT_W-1:8], rx_data};
    assign len_legal     = (len_rx != '0) && (len_rx <= MAX_WORDS);
    assign count_inc     = count + CNT_W'(1);
    assign session_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (start) state_next = ST_LEN_HI;
            ST_LEN_HI:  if (accept) state_next = ST_LEN_LO;
            ST_LEN_LO:  if (accept) state_next = len_legal ? ST_DATA_HI : ST_ERROR;
            ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
            ST_DATA_LO: if (accept) state_next = ST_WRITE;
            ST_WRITE:   state_next = (count_inc < len) ? ST_DATA_HI : ST_CSUM;
            ST_CSUM:    if (accept) state_next = (sum_next == 8'h00) ? ST_DONE : ST_ERROR;
            ST_DONE:    if (start) state_next = ST_LEN_HI;
            ST_ERROR:   if (start) state_next = ST_LEN_HI;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state)
            ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM: rx_ready = 1'b1;
            ST_WRITE: mem_we = 1'b1;
            ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ST_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: the running checksum covers every accepted byte, header and CSUM included.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum    <= '0;
            len    <= '0;
            count  <= '0;
            addr   <= '0;
            hi_nib <= '0;
            wdata  <= '0;
        end else if (session_start) begin
            sum   <= '0;
            count <= '0;
            addr  <= '0;
        end else begin
            if (accept) sum <= sum_next;
            if (accept && state == ST_LEN_HI)  len[CNT_W-1:8] <= rx_data[3:0];
            if (accept && state == ST_LEN_LO)  len[7:0] <= rx_data;
            if (accept && state == ST_DATA_HI) hi_nib <= rx_data[3:0];
            if (accept && state == ST_DATA_LO) wdata <= {hi_nib, rx_data};
            if (state == ST_WRITE) begin
                addr  <= addr + ADDR_W'(1);
                count <= count_inc;
            end
        end
    end

    assign mem_addr  = addr;
    assign mem_wdata = wdata;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [10:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        error;

    prog_loader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        string       name;
        logic [95:0] bytes;
        int          n;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  stream[$];
    logic [22:0] got_w[$];
    logic [22:0] exp_w[$];
    bit          m_done;
    bit          m_err;
    vec_t        vecs[7];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (mem_we === 1'b1) got_w.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: parse the image by the stream rules, producing the expected write list and outcome.
    task automatic model_run();
        int         n;
        logic [7:0] s;
        exp_w.delete();
        n = {stream[0][3:0], stream[1]};
        if (n == 0 || n > 2048) begin
            m_done = 1'b0;
            m_err  = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            logic [10:0] a;
            a = k[10:0];
            exp_w.push_back({a, stream[2+2*k][3:0], stream[3+2*k]});
        end
        s = 8'h00;
        for (int i = 0; i < 2*n + 3; i++) s = s + stream[i];
        m_done = (s == 8'h00);
        m_err  = !m_done;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        @(negedge clock);
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            check("rx_ready timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) send_byte(stream[i], gaps);
    endtask

    task automatic check_result(input string nm, input bit exp_done, input bit exp_err);
        int m;
        @(negedge clock);
        #1;
        model_run();
        check({nm, " nwrites"}, got_w.size(), exp_w.size());
        m = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < m; i++)
            if (got_w[i] !== exp_w[i]) check($sformatf("%s write%0d", nm, i), got_w[i], exp_w[i]);
        check({nm, " done"},     done,     exp_done);
        check({nm, " error"},    error,    exp_err);
        check({nm, " cpu_hold"}, cpu_hold, !exp_done);
        check({nm, " rx_ready"}, rx_ready, 1'b0);
        check({nm, " mem_addr"}, mem_addr, exp_w.size() % 2048);
    endtask

    task automatic load_good();
        stream.delete();
        stream = '{8'h00, 8'h03, 8'h04, 8'hC3, 8'h04, 8'hA3, 8'h0B, 8'hF2, 8'h92};
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        vecs[0] = '{"good",      96'h00_03_04_C3_04_A3_0B_F2_92, 9, 1'b1, 1'b0};
        vecs[1] = '{"bad_csum",  96'h00_03_04_C3_04_A3_0B_F2_93, 9, 1'b0, 1'b1};
        vecs[2] = '{"hdr_zero",  96'h00_00,                      2, 1'b0, 1'b1};
        vecs[3] = '{"hdr_2049",  96'h08_01,                      2, 1'b0, 1'b1};
        vecs[4] = '{"n1",        96'h00_01_FA_BC_49,             5, 1'b1, 1'b0};
        vecs[5] = '{"lenhi_nib", 96'hF0_01_12_34_C9,             5, 1'b1, 1'b0};
        vecs[6] = '{"hdr_10_00", 96'h10_00,                      2, 1'b0, 1'b1};

        repeat (3) @(negedge clock);
        check("rst rx_ready",  rx_ready,  1'b0);
        check("rst mem_we",    mem_we,    1'b0);
        check("rst mem_addr",  mem_addr,  11'd0);
        check("rst mem_wdata", mem_wdata, 12'd0);
        check("rst cpu_hold",  cpu_hold,  1'b1);
        check("rst done",      done,      1'b0);
        check("rst error",     error,     1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle rx_ready", rx_ready, 1'b0);

        foreach (vecs[v]) begin
            stream.delete();
            for (int i = 0; i < vecs[v].n; i++)
                stream.push_back(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8]);
            got_w.delete();
            pulse_start();
            send_range(0, vecs[v].n - 1, 1'b1);
            check_result(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err);
        end

        for (int r = 0; r < 20; r++) begin
            int         n;
            logic [7:0] s;
            n = $urandom_range(1, 6);
            stream.delete();
            stream.push_back({4'($urandom_range(0, 15)), 4'h0});
            stream.push_back(8'(n));
            for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom_range(0, 255)));
            s = 8'h00;
            foreach (stream[i]) s = s + stream[i];
            s = 8'h00 - s;
            if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
            stream.push_back(s);
            model_run();
            got_w.delete();
            pulse_start();
            send_range(0, stream.size() - 1, 1'b1);
            check_result($sformatf("rand%0d", r), m_done, m_err);
        end

        begin
            logic [7:0] s;
            stream.delete();
            stream.push_back(8'h08);
            stream.push_back(8'h00);
            for (int k = 0; k < 2048; k++) begin
                stream.push_back(8'(k >> 8));
                stream.push_back(8'(k & 255));
            end
            s = 8'h00;
            foreach (stream[i]) s = s + stream[i];
            stream.push_back(8'h00 - s);
            got_w.delete();
            pulse_start();
            send_range(0, stream.size() - 1, 1'b0);
            check_result("n2048", 1'b1, 1'b0);
            check("n2048 count", got_w.size(), 2048);
            if (got_w.size() == 2048) check("n2048 last", got_w[2047], {11'd2047, 12'h7FF});
        end

        load_good();
        got_w.delete();
        pulse_start();
        send_range(0, 1, 1'b1);
        pulse_start();
        send_range(2, 8, 1'b1);
        check_result("start_in_data_hi", 1'b1, 1'b0);

        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        check("restart done",     done,     1'b0);
        check("restart cpu_hold", cpu_hold, 1'b1);
        check("restart rx_ready", rx_ready, 1'b1);
        got_w.delete();
        send_range(0, 8, 1'b1);
        check_result("reload", 1'b1, 1'b0);

        load_good();
        got_w.delete();
        pulse_start();
        send_range(0, 3, 1'b1);
        @(negedge clock);
        #1;
        check("mid writes before reset", got_w.size(), 1);
        reset = 1'b1;
        #1;
        check("mid rst mem_we",   mem_we,   1'b0);
        check("mid rst cpu_hold", cpu_hold, 1'b1);
        check("mid rst rx_ready", rx_ready, 1'b0);
        check("mid rst mem_addr", mem_addr, 11'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom_range(0, 255));
            start    = 1'b1;
        end
        @(negedge clock);
        rx_valid = 1'b0;
        start    = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("post rst writes",   got_w.size(), 1);
        check("post rst rx_ready", rx_ready, 1'b0);
        check("post rst cpu_hold", cpu_hold, 1'b1);
        got_w.delete();
        pulse_start();
        send_range(0, 8, 1'b1);
        check_result("after_reset", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
